// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports, the single-port memory side and the busy flag
// for dmem_arbiter. slave = arbiter side, master = requesters plus memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              resp0_valid;
    logic [DATA_W-1:0] resp0_rdata;
    logic              resp0_err;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp1_rdata;
    logic              resp1_err;

    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_datain;
    logic              mem_w;
    logic              mem_r;
    logic [DATA_W-1:0] mem_dataout;
    logic              busy;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_dataout,
        output req0_ready, resp0_valid, resp0_rdata, resp0_err,
        output req1_ready, resp1_valid, resp1_rdata, resp1_err,
        output mem_adr, mem_datain, mem_w, mem_r, busy
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_dataout,
        input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
        input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
        input  mem_adr, mem_datain, mem_w, mem_r, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port 64-bit data memory.
// Fixed timing: accept, one ACCESS cycle, one RESP cycle; range errors never touch memory.
module dmem_arbiter #(
    parameter int MEM_BYTES = 32,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 8);

    state_t            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              gnt;
    logic              accept;
    logic              in_access;
    logic              in_resp;
    logic [ADDR_W-1:0] sel_addr;

    // Ties go to the port not served last; a lone requester always wins.
    always_comb begin
        gnt = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt = ~last_gnt_q;
        end else if (bus.req1_valid) begin
            gnt = 1'b1;
        end
    end

    assign accept         = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = accept && !gnt;
    assign bus.req1_ready = accept && gnt;
    assign sel_addr       = gnt ? bus.req1_addr : bus.req0_addr;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = ACCESS;
                    last_gnt_d = gnt;
                    port_d     = gnt;
                    we_d       = gnt ? bus.req1_we : bus.req0_we;
                    addr_d     = sel_addr;
                    wdata_d    = gnt ? bus.req1_wdata : bus.req0_wdata;
                    err_d      = sel_addr > MAX_ADDR;
                end
            end
            ACCESS: begin
                state_d = RESP;
                // mem_dataout floats unless mem_r is high, so only sample on a legal read.
                rdata_d = (!we_q && !err_q) ? bus.mem_dataout : '0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            port_q     <= port_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Memory strobes decode from state so an async reset kills a pending write at once.
    assign in_access      = (state_q == ACCESS);
    assign in_resp        = (state_q == RESP);
    assign bus.mem_adr    = in_access ? addr_q : '0;
    assign bus.mem_datain = in_access ? wdata_q : '0;
    assign bus.mem_w      = in_access && we_q && !err_q;
    assign bus.mem_r      = in_access && !we_q && !err_q;

    assign bus.resp0_valid = in_resp && !port_q;
    assign bus.resp0_rdata = (in_resp && !port_q) ? rdata_q : '0;
    assign bus.resp0_err   = in_resp && !port_q && err_q;
    assign bus.resp1_valid = in_resp && port_q;
    assign bus.resp1_rdata = (in_resp && port_q) ? rdata_q : '0;
    assign bus.resp1_err   = in_resp && port_q && err_q;

    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences and a
// randomized run against a cycle-numbered transaction model with its own memory image.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic mem_load;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    dmem_arbiter #(.MEM_BYTES(32), .ADDR_W(64), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory under the arbiter and the bench's expected image of it.
    logic [7:0]  mem     [32];
    logic [7:0]  ref_mem [32];
    logic [63:0] mem_rd;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
        end else if (bus.mem_w) begin
            for (int i = 0; i < 8; i++)
                if (int'(bus.mem_adr[5:0]) + i < 32)
                    mem[int'(bus.mem_adr[5:0]) + i] <= bus.mem_datain[8*i +: 8];
        end
    end

    always_comb begin
        mem_rd = '0;
        for (int i = 0; i < 8; i++)
            if (int'(bus.mem_adr[5:0]) + i < 32)
                mem_rd[8*i +: 8] = mem[int'(bus.mem_adr[5:0]) + i];
    end

    assign bus.mem_dataout = bus.mem_r ? mem_rd : 'z;

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] d = '0;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = ref_mem[int'(a[5:0]) + i];
        return d;
    endfunction

    task automatic ref_write(input logic [63:0] a, input logic [63:0] d);
        for (int i = 0; i < 8; i++) ref_mem[int'(a[5:0]) + i] = d[8*i +: 8];
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v0, input bit v1, input bit we,
                         input logic [63:0] addr, input logic [63:0] wd);
        bus.req0_valid = v0; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = wd;
        bus.req1_valid = v1; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = wd;
    endtask

    // One complete transaction from IDLE; e0/e1 name the port expected to win.
    task automatic run_txn(input string nm, input bit v0, input bit v1, input bit we,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input bit e0, input bit e1, input bit ee);
        logic [63:0] exp_rd;
        drive(v0, v1, we, addr, wd);
        @(negedge clk);
        chk({nm, " ready"}, {bus.req0_ready, bus.req1_ready, bus.mem_w, bus.mem_r, bus.busy},
            {e0, e1, 3'b000});
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0);
        if (!(e0 || e1)) return;
        @(negedge clk);
        chk({nm, " access"}, {bus.mem_w, bus.mem_r, bus.busy}, {we & ~ee, ~we & ~ee, 1'b1});
        chk({nm, " adr"}, bus.mem_adr, addr);
        exp_rd = (we || ee) ? 64'd0 : ref_read(addr);
        if (we && !ee) ref_write(addr, wd);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, " resp"}, {bus.resp0_valid, bus.resp0_err, bus.resp1_valid, bus.resp1_err,
                            bus.mem_w, bus.mem_r, bus.busy},
            {e0, e0 & ee, e1, e1 & ee, 3'b001});
        chk({nm, " rdata"}, e0 ? bus.resp0_rdata : bus.resp1_rdata, exp_rd);
        chk({nm, " idle port rdata"}, e0 ? bus.resp1_rdata : bus.resp0_rdata, 64'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          v0, v1, we;
        logic [63:0] addr, wd;
        bit          e0, e1, ee;
    } vec_t;

    typedef struct {
        bit          v, we;
        logic [63:0] addr, wd;
    } rq_t;

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return 64'($urandom_range(0, 24));
            3:       return 64'($urandom_range(25, 31));
            4:       return {32'($urandom_range(1, 255)), 32'($urandom)};
            default: return 64'd24;
        endcase
    endfunction

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl [10];
        rq_t         rq [2];
        logic [63:0] cur, exp_ctrl;
        int          nreads, acc_n, last, g;
        bit          idle, in_acc, in_rsp, p_port, p_we, p_err;
        logic [63:0] p_addr, p_wd, p_rd;

        // Arbitration and range vectors, applied one transaction at a time after reset.
        tbl[0] = '{1, 1, 0, 64'd0,            64'd0,                  1, 0, 0};
        tbl[1] = '{1, 1, 0, 64'd16,           64'd0,                  0, 1, 0};
        tbl[2] = '{1, 1, 1, 64'd24,           64'hA5A5_0102_0304_5A5A, 1, 0, 0};
        tbl[3] = '{0, 1, 1, 64'd25,           64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1};
        tbl[4] = '{1, 0, 0, 64'h1_0000_0000,  64'd0,                  1, 0, 1};
        tbl[5] = '{1, 1, 0, 64'd7,            64'd0,                  0, 1, 0};
        tbl[6] = '{1, 1, 1, 64'd3,            64'h0BAD_F00D_CAFE_1234, 1, 0, 0};
        tbl[7] = '{0, 0, 0, 64'd0,            64'd0,                  0, 0, 0};
        tbl[8] = '{1, 1, 0, 64'd3,            64'd0,                  0, 1, 0};
        tbl[9] = '{1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,            1, 0, 1};

        for (int i = 0; i < 32; i++) ref_mem[i] = 8'($urandom);
        rst = 1'b1; mem_load = 1'b1;
        drive(0, 0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1 mem_load = 1'b0;
        @(negedge clk);
        chk("reset ctrl", {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp0_err,
                           bus.resp1_valid, bus.resp1_err, bus.mem_w, bus.mem_r, bus.busy}, 64'd0);
        chk("reset data", bus.mem_adr | bus.mem_datain | bus.resp0_rdata | bus.resp1_rdata, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 10; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].we, tbl[i].addr,
                    tbl[i].wd, tbl[i].e0, tbl[i].e1, tbl[i].ee);

        // Loader writes, pipeline reads back; memory must hold it little-endian.
        run_txn("p1 write", 0, 1, 1, 64'd8, 64'h1122_3344_5566_7788, 0, 1, 0);
        run_txn("p0 read", 1, 0, 0, 64'd8, 64'd0, 1, 0, 0);
        cur = '0;
        for (int i = 0; i < 8; i++) cur[8*i +: 8] = mem[8 + i];
        chk("bytes 8..15", cur, 64'h1122_3344_5566_7788);

        cur = '0;
        for (int i = 0; i < 32; i++) cur[0] = cur[0] | (mem[i] !== ref_mem[i]);
        chk("memory image", cur, 64'd0);

        // Single requester holding valid across four reads: ready every third cycle.
        nreads = 0;
        drive(1, 0, 0, 64'd0, '0);
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("repeat c%0d", k), {bus.req0_ready, bus.req1_ready}, {(k % 3 == 0), 1'b0});
            @(posedge clk); #1;
            if (k % 3 == 0) begin
                nreads++;
                if (nreads == 4) drive(0, 0, 0, '0, '0);
                else bus.req0_addr = 64'(8 * nreads);
            end
        end

        // Reset during the ACCESS cycle of a write must cancel it.
        drive(1, 0, 1, 64'd0, 64'hDEAD_BEEF_0000_0000);
        @(negedge clk);
        chk("rst-mid ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0);
        #1 chk("rst-mid access", {bus.mem_w, bus.busy}, 2'b11);
        rst = 1'b1;
        #1 chk("rst-mid drop", {bus.mem_w, bus.mem_r, bus.busy}, 3'b000);
        @(negedge clk);
        chk("rst-mid no resp", {bus.resp0_valid, bus.resp1_valid, bus.mem_w}, 3'b000);
        @(posedge clk); #1 rst = 1'b0;
        cur = '0;
        for (int i = 0; i < 8; i++) cur[8*i +: 8] = mem[i];
        chk("rst-mid bytes 0..7", cur, ref_read(64'd0));
        run_txn("post-rst tie", 1, 1, 0, 64'd0, 64'd0, 1, 0, 0);

        // Randomized traffic against the transaction model; starts from a fresh reset.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        acc_n = -10; last = 1;
        p_port = 0; p_we = 0; p_err = 0; p_addr = '0; p_wd = '0; p_rd = '0;
        for (int p = 0; p < 2; p++) rq[p] = '{0, 0, '0, '0};
        for (int n = 0; n < 3000; n++) begin
            bus.req0_valid = rq[0].v; bus.req0_we = rq[0].we;
            bus.req0_addr = rq[0].addr; bus.req0_wdata = rq[0].wd;
            bus.req1_valid = rq[1].v; bus.req1_we = rq[1].we;
            bus.req1_addr = rq[1].addr; bus.req1_wdata = rq[1].wd;
            @(negedge clk);
            idle   = (n >= acc_n + 3);
            in_acc = (n == acc_n + 1);
            in_rsp = (n == acc_n + 2);
            g = -1;
            if (idle) begin
                if (rq[0].v && rq[1].v) g = 1 - last;
                else if (rq[0].v) g = 0;
                else if (rq[1].v) g = 1;
            end
            exp_ctrl = {55'd0, g == 0, g == 1, !idle,
                        in_acc && p_we && !p_err, in_acc && !p_we && !p_err,
                        in_rsp && !p_port, in_rsp && !p_port && p_err,
                        in_rsp && p_port, in_rsp && p_port && p_err};
            chk($sformatf("rnd ctrl c%0d", n),
                {bus.req0_ready, bus.req1_ready, bus.busy, bus.mem_w, bus.mem_r,
                 bus.resp0_valid, bus.resp0_err, bus.resp1_valid, bus.resp1_err}, exp_ctrl);
            chk($sformatf("rnd mem_adr c%0d", n), bus.mem_adr, in_acc ? p_addr : 64'd0);
            chk($sformatf("rnd datain c%0d", n), bus.mem_datain, in_acc ? p_wd : 64'd0);
            chk($sformatf("rnd rdata0 c%0d", n), bus.resp0_rdata,
                (in_rsp && !p_port) ? p_rd : 64'd0);
            chk($sformatf("rnd rdata1 c%0d", n), bus.resp1_rdata,
                (in_rsp && p_port) ? p_rd : 64'd0);
            if (in_acc) begin
                p_rd = (p_we || p_err) ? 64'd0 : ref_read(p_addr);
                if (p_we && !p_err) ref_write(p_addr, p_wd);
            end
            @(posedge clk); #1;
            if (g >= 0) begin
                acc_n  = n;
                last   = g;
                p_port = (g == 1);
                p_we   = rq[g].we;
                p_addr = rq[g].addr;
                p_wd   = rq[g].wd;
                p_err  = rq[g].addr > 64'd24;
                rq[g].v = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!rq[p].v) begin
                    if ($urandom_range(0, 1) == 1)
                        rq[p] = '{1, 1'($urandom_range(0, 1)), rand_addr(),
                                  {32'($urandom), 32'($urandom)}};
                end else if ($urandom_range(0, 7) == 0) begin
                    rq[p].v = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
